// File: rtl/shift_arb_seq_pkg.sv
// Shared types and constants for the two-requester shift-register loader.
package shift_arb_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int DEF_WIDTH = 4;
    localparam int NUM_REQ   = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; ptr_q names the requester that wins a tie.
module rr_arb2
    import shift_arb_seq_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic [NUM_REQ-1:0] request,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    logic ptr_q;

    always_comb begin
        grant = '0;
        case (request)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = '0;
        endcase
    end

    // On advance the pointer moves away from whoever currently holds the grant.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ptr_q <= 1'b0;
        end else if (advance) begin
            ptr_q <= grant[0];
        end
    end

endmodule

// File: rtl/shift_arb_seq.sv
// Arbitrates two requesters and serially loads the winner's word into an
// external bidirectional shift register. SHIFT_ARB_SEQ_FIXED_PRIO_EN selects
// fixed priority (req0 wins ties) instead of round-robin.
//
// state | meaning
// IDLE  | waiting for a valid request; ready driven combinationally
// SHIFT | N cycles of serial data, cnt 0..N-1
// DONE  | word present in register; done pulse, pointer advance
module shift_arb_seq
    import shift_arb_seq_pkg::*;
#(
    parameter int N = DEF_WIDTH
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               req0_valid,
    input  logic               req0_dir,
    input  logic [N-1:0]       req0_data,
    output logic               req0_ready,
    output logic               req0_done,
    input  logic               req1_valid,
    input  logic               req1_dir,
    input  logic [N-1:0]       req1_data,
    output logic               req1_ready,
    output logic               req1_done,
    output logic               sr_rst,
    output logic               sr_dir,
    output logic               sr_data,
    output logic               sr_word_valid,
    output logic [NUM_REQ-1:0] gnt
);

    localparam int CW = $clog2(N);

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [N-1:0]       data_q;
    logic               dir_q;
    logic [NUM_REQ-1:0] gnt_q;
    logic               sr_data_q;

    logic [NUM_REQ-1:0] req_vec;
    logic [NUM_REQ-1:0] arb_gnt;
    logic               accept;
    logic [N-1:0]       sel_data;
    logic               sel_dir;
    logic [CW-1:0]      cnt_nx;
    logic [CW-1:0]      rev_nx;

    assign req_vec = {req1_valid, req0_valid};

`ifdef SHIFT_ARB_SEQ_FIXED_PRIO_EN
    assign arb_gnt = req_vec[0] ? 2'b01 : (req_vec[1] ? 2'b10 : 2'b00);
`else
    // Outside IDLE the owner is fed back as the request so grant reflects it at DONE.
    logic [NUM_REQ-1:0] arb_req;
    assign arb_req = (state_q == IDLE) ? req_vec : gnt_q;

    rr_arb2 u_arb (
        .CLK     (CLK),
        .RST     (RST),
        .request (arb_req),
        .advance (state_q == DONE),
        .grant   (arb_gnt)
    );
`endif

    assign accept     = (state_q == IDLE) && !RST && (arb_gnt != '0);
    assign req0_ready = accept && arb_gnt[0];
    assign req1_ready = accept && arb_gnt[1];

    assign sel_data = arb_gnt[1] ? req1_data : req0_data;
    assign sel_dir  = arb_gnt[1] ? req1_dir  : req0_dir;
    assign cnt_nx   = cnt_q + 1'b1;
    assign rev_nx   = CW'(N - 1) - cnt_nx;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            data_q    <= '0;
            dir_q     <= 1'b0;
            gnt_q     <= '0;
            sr_data_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        data_q    <= sel_data;
                        dir_q     <= sel_dir;
                        gnt_q     <= arb_gnt;
                        cnt_q     <= '0;
                        sr_data_q <= sel_dir ? sel_data[0] : sel_data[N-1];
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt_q == CW'(N - 1)) begin
                        sr_data_q <= 1'b0;
                        state_q   <= DONE;
                    end else begin
                        cnt_q     <= cnt_nx;
                        sr_data_q <= dir_q ? data_q[cnt_nx] : data_q[rev_nx];
                    end
                end
                DONE: begin
                    gnt_q   <= '0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign sr_rst        = RST;
    assign sr_dir        = dir_q;
    assign sr_data       = sr_data_q;
    assign gnt           = gnt_q;
    assign sr_word_valid = (state_q == DONE) && !RST;
    assign req0_done     = (state_q == DONE) && gnt_q[0] && !RST;
    assign req1_done     = (state_q == DONE) && gnt_q[1] && !RST;

endmodule

// File: doc/shift_arb_seq.md
SHIFT_ARB_SEQ -- requirements
Module: shift_arb_seq

Interface
REQ-001 Parameter N, default 4: bidirectional shift register width; legal range N >= 3.
REQ-002 CLK  input  1  clock; all state changes on rising edge.
REQ-003 RST  input  1  reset, synchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 transfer request.
REQ-005 req0_dir  input  1  requester 0 direction; 1 = right shift, 0 = left shift.
REQ-006 req0_data  input  N  requester 0 word to load.
REQ-007 req0_ready  output  1  requester 0 accept; transfer occurs when valid and ready are both high at a rising edge.
REQ-008 req0_done  output  1  one-cycle pulse when requester 0's word is present in the register.
REQ-009 req1_valid, req1_dir, req1_data, req1_ready, req1_done: same directions, widths and meanings for requester 1.
REQ-010 sr_rst  output  1  reset to the shift register.
REQ-011 sr_dir  output  1  direction to the shift register.
REQ-012 sr_data  output  1  serial input bit to the shift register.
REQ-013 sr_word_valid  output  1  high while the shift register output equals the granted word.
REQ-014 gnt  output  2  one-hot owner of the current transaction; 00 when idle.

Function
REQ-015 The attached shift register shifts on every CLK edge; the controller shall drive sr_dir and sr_data every cycle.
REQ-016 States: IDLE, SHIFT, DONE.
REQ-017 IDLE: if any valid is high, the arbiter picks one requester. Its ready is high combinationally that cycle. The block latches data and dir, sets gnt, clears cnt and moves to SHIFT. Otherwise it stays in IDLE.
REQ-018 Only one ready shall be high in any cycle; ready is low in SHIFT and DONE.
REQ-019 SHIFT lasts exactly N cycles; cnt runs 0..N-1; at cnt == N-1 the next state is DONE.
REQ-020 SHIFT bit order, dir = 1: sr_data = data[cnt], so LSB goes first and ends at bit 0.
REQ-021 SHIFT bit order, dir = 0: sr_data = data[N-1-cnt], so MSB goes first and ends at bit N-1.
REQ-022 sr_dir equals the latched dir during SHIFT and DONE. It holds its last value in IDLE.
REQ-023 sr_data is 0 in IDLE and DONE.
REQ-024 DONE lasts one cycle: sr_word_valid = 1; the granted requester's done = 1; the round-robin pointer advances to the other requester; next state is IDLE.
REQ-025 Latency from accept edge to done pulse is N+1 cycles. A new accept is possible the cycle after DONE.
REQ-026 Round-robin when both requesters are valid: grant the one the pointer selects. A lone valid requester is granted regardless of the pointer.
REQ-027 Changes on valid, dir or data after accept shall not affect the transaction in flight.
REQ-028 gnt stays stable from accept through DONE; it is 00 in IDLE.

Reset
REQ-029 RST high: next state IDLE; cnt = 0; gnt = 00; pointer selects req0; sr_dir = 0; latched data = 0.
REQ-030 RST high: all ready, done and sr_word_valid outputs are 0; sr_rst = 1.
REQ-031 sr_rst equals RST combinationally.
REQ-032 RST during SHIFT or DONE aborts the transaction; no done pulse is issued for it.

Configuration
REQ-033 Macro SHIFT_ARB_SEQ_FIXED_PRIO_EN.
REQ-034 With the macro defined, arbitration is fixed priority: req0 always wins a tie, and the pointer logic is removed.
REQ-035 Without the macro, arbitration is round-robin per REQ-026.

Structure
REQ-036 Package shift_arb_seq_pkg holds the state typedef (IDLE/SHIFT/DONE), the default width constant 4 and the requester count constant 2.
REQ-037 Sub-module rr_arb2: 2-way round-robin arbiter with request[1:0], advance and grant[1:0] ports, instantiated only without the macro.
REQ-038 The bench instantiates shift_arb_seq with the existing bidirectional shift register at N = 3 and N = 4.

Verification
REQ-039 Test 1, N = 4: req0 valid, dir = 1, data = 1011. sr_data sequence 1,1,0,1 over 4 cycles, then register = 1011, sr_word_valid = 1 and req0_done = 1.
REQ-040 Test 2, N = 4: req1 valid, dir = 0, data = 0110. sr_data sequence 0,1,1,0, then register = 0110 and req1_done pulses at accept + 5 cycles.
REQ-041 Test 3: both valid continuously. Grants alternate req0, req1, req0, req1 without the macro; with the macro, only req0 is granted.
REQ-042 Test 4: RST asserted at SHIFT cnt = 2. Next cycle: IDLE, gnt = 00, register = 000..0, and no done pulse ever appears for that word.
REQ-043 Test 5: after accept, req0_data is changed and req0_valid is dropped mid-SHIFT. The originally latched word is still delivered and done still pulses.
